dct2d_sequencer: RTL

Sequencer for the shared 8-point 1D DCT engine in the 2D DCT datapath. It loads one 8x8 block into the transpose RAM from the external input, then runs a row pass followed by a column pass. For each line it reads 8 samples into the engine, starts it, waits for completion, and writes the 8 results back in place. It owns the line and index counters and the transpose address mapping, so the datapath needs no external counters.

---
 rtl/dct_pkg.sv | 28 ++
 rtl/dct_addr_gen.sv | 48 ++++
 rtl/dct2d_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared definitions for the 2D DCT sequencer slice.
//   - state_t : sequencer FSM states
//   - N       : points per 1D line (fixed at 8)
//   - ADDR_W  : transpose RAM address width (log2 of N*N)
//   - LINE_W  : width of the line / index counters (log2 of N)
//   - PASS_ROW / PASS_COL : encoding of the pass flag
package dct_pkg;

  localparam int N      = 8;
  localparam int ADDR_W = 6;
  localparam int LINE_W = 3;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

  // IDLE is encoded as 0 so the exported state reads 0 out of reset.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_KICK  = 3'd4,
    S_WAIT  = 3'd5,
    S_WB    = 3'd6,
    S_FIN   = 3'd7
  } state_t;

endpackage

// File: rtl/dct_addr_gen.sv
// dct_addr_gen: counters and transpose address mapping for the DCT sequencer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero every counter and return to the row pass
//   load_step  : advance the 6-bit load counter
//   idx_step   : advance the sample index (wraps 7 -> 0)
//   line_step  : advance the line counter (wraps 7 -> 0)
//   pass_set   : switch to the column pass
//   load_cnt   : current load address
//   idx, line  : current sample index and line
//   pass       : 0 = row pass, 1 = column pass
//   xaddr      : in-place RAM address for (line, idx) under the current pass
module dct_addr_gen
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_step,
  input  logic              idx_step,
  input  logic              line_step,
  input  logic              pass_set,
  output logic [ADDR_W-1:0] load_cnt,
  output logic [LINE_W-1:0] idx,
  output logic [LINE_W-1:0] line,
  output logic              pass,
  output logic [ADDR_W-1:0] xaddr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      load_cnt <= '0;
      idx      <= '0;
      line     <= '0;
      pass     <= PASS_ROW;
    end else begin
      if (load_step) load_cnt <= load_cnt + ADDR_W'(1);
      if (idx_step)  idx      <= idx + LINE_W'(1);
      if (line_step) line     <= line + LINE_W'(1);
      if (pass_set)  pass     <= PASS_COL;
    end
  end

  // Row pass walks a row of the row-major block; column pass walks a column,
  // which is the transpose of the same storage.
  assign xaddr = (pass == PASS_COL) ? {idx, line} : {line, idx};

endmodule

// File: rtl/dct2d_sequencer.sv
// dct2d_sequencer: control for a shared 8-point 1D DCT engine doing a 2D DCT
// in place in an 8x8 transpose RAM (load, 8 row lines, 8 column lines).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a block (sampled in IDLE only)
//   in_valid / in_ready : external sample handshake during LOAD
//   ram_cs/we/re/addr   : RAM strobes and address (read data 1 cycle later)
//   in_sel              : RAM write-data mux, 0 = external, 1 = engine lane
//   vec_load, vec_idx   : load RAM read data into engine input lane vec_idx
//   res_sel             : engine output lane written back to RAM
//   dct_start           : one-cycle engine start pulse
//   dct_done            : engine result ready (sampled in WAIT only)
//   pass                : 0 = row pass, 1 = column pass
//   busy                : high in every state except IDLE
//   done                : one-cycle block-complete pulse
//   fsm_state           : current FSM state, for observation
//
// Handshake: a load beat transfers on a rising edge where in_valid && in_ready.
// in_ready is high for the whole of LOAD regardless of in_valid; the source may
// hold in_valid low for any number of cycles; exactly 64 beats are taken.
module dct2d_sequencer
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              in_sel,
  output logic              vec_load,
  output logic [LINE_W-1:0] vec_idx,
  output logic [LINE_W-1:0] res_sel,
  output logic              dct_start,
  input  logic              dct_done,
  output logic              pass,
  output logic              busy,
  output logic              done,
  output state_t            fsm_state
);

  state_t state;
  state_t next_state;

  logic              cnt_clear;
  logic              load_step;
  logic              idx_step;
  logic              line_step;
  logic              pass_set;
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] xaddr;
  logic [LINE_W-1:0] idx;
  logic [LINE_W-1:0] line;
  logic              pass_r;

  dct_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .load_step (load_step),
    .idx_step  (idx_step),
    .line_step (line_step),
    .pass_set  (pass_set),
    .load_cnt  (load_cnt),
    .idx       (idx),
    .line      (line),
    .pass      (pass_r),
    .xaddr     (xaddr)
  );

  // RAM read data arrives one cycle after the READ address, so the engine
  // lane load is the READ cycle delayed by one; the final lane lands in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vec_load <= 1'b0;
      vec_idx  <= '0;
    end else begin
      state    <= next_state;
      vec_load <= (state == S_READ);
      vec_idx  <= (state == S_READ) ? idx : '0;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    load_step  = 1'b0;
    idx_step   = 1'b0;
    line_step  = 1'b0;
    pass_set   = 1'b0;
    in_ready   = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    in_sel     = 1'b0;
    res_sel    = '0;
    dct_start  = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_clear  = 1'b1;
          next_state = S_LOAD;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        ram_cs   = 1'b1;
        ram_we   = in_valid;
        ram_addr = load_cnt;
        if (in_valid) begin
          load_step = 1'b1;
          // idx and line are still zero from the clear on start.
          if (load_cnt == ADDR_W'(63)) next_state = S_READ;
        end
      end

      S_READ: begin
        ram_cs   = 1'b1;
        ram_re   = 1'b1;
        ram_addr = xaddr;
        idx_step = 1'b1;
        // idx wraps back to 0 here, ready for write-back.
        if (idx == LINE_W'(7)) next_state = S_DRAIN;
      end

      S_DRAIN: next_state = S_KICK;

      S_KICK: begin
        dct_start  = 1'b1;
        next_state = S_WAIT;
      end

      S_WAIT: begin
        if (dct_done) next_state = S_WB;
      end

      S_WB: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        in_sel   = 1'b1;
        res_sel  = idx;
        ram_addr = xaddr;
        idx_step = 1'b1;
        if (idx == LINE_W'(7)) begin
          // line wraps 7 -> 0 at the end of each pass.
          line_step = 1'b1;
          if (line == LINE_W'(7) && pass_r == PASS_COL) begin
            next_state = S_FIN;
          end else begin
            if (line == LINE_W'(7)) pass_set = 1'b1;
            next_state = S_READ;
          end
        end
      end

      S_FIN: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end

      default: next_state = S_IDLE;
    endcase
  end

  // The pass register keeps its last value after a block; masking it in IDLE
  // keeps every output at 0 there.
  assign pass      = (state != S_IDLE) && (pass_r == PASS_COL);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule
